pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into BLOCK-bit slices, and one slice is resolved per pipeline stage. Each stage uses a combinational lookahead block, and the carry ripples stage to stage through registers. It provides a valid/ready handshake on both sides, sustains one operation per cycle, and adds signed-overflow detection and a subtract mode. It replaces the single-cycle combinational adder on datapaths wider than 16 bits, where the full lookahead chain would not close timing.

## Interface
- BITWIDTH, 32, operand/result width; must be a multiple of BLOCK and at least BLOCK.
- BLOCK, 8, slice width resolved per stage; must be at least 2.
- STAGES (localparam), BITWIDTH/BLOCK, pipeline depth.

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- bits_a  input  BITWIDTH  operand A.
- bits_b  input  BITWIDTH  operand B.
- carry_in  input  1  carry in (add) or not-borrow in (sub).
- sub  input  1  0 selects add; 1 selects subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  BITWIDTH  result.
- carry_out  output  1  carry out of the MSB (for sub, 1 means no borrow).
- overflow  output  1  two's-complement signed overflow.

## Operation
- Effective operands: b_eff = sub ? ~bits_b : bits_b; c0 = carry_in ^ sub.
  - sub=1 with carry_in=0 gives A−B.
  - sub=1 with carry_in=1 gives A−B−1.
- Stage k (0..STAGES−1) computes slice k of A + b_eff with the carry registered from stage k−1 (c0 for stage 0). It produces slice sum and slice carry via per-bit propagate/generate and block lookahead.
- Not-yet-processed upper slices travel forward with the beat. Already-computed lower sum slices are carried forward so all slices emerge together (skew/deskew registers).
- Final stage outputs:
  - carry_out is the carry out of bit BITWIDTH−1.
  - overflow = carry into bit BITWIDTH−1 XOR carry out of bit BITWIDTH−1.
- Elastic pipeline: each stage has a valid bit.
  - Stage k loads when its output is empty or being taken this cycle: ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
  - Bubbles collapse.
- in_ready = ready_0 while rst is low. It is a combinational function of state and out_ready (out_ready → in_ready path is permitted).
- Beats leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset values:
  - in_ready=0 during any cycle with rst=1.
  - All stage valid bits cleared, so out_valid=0.
  - sum=0, carry_out=0, overflow=0.
- Latency: a beat accepted at edge N (in_valid && in_ready) is presented with out_valid=1 after edge N+STAGES−1 when there are no stalls. That is STAGES cycles including the acceptance cycle; for defaults, the result is valid 4 cycles after acceptance.
- Throughput: one beat per cycle when out_ready stays high.
- Stall: while out_valid && !out_ready, the values of sum, carry_out and overflow are held stable, and upstream stages fill until in_ready=0. At most STAGES beats are in flight.
- Simultaneous accept and output on the same edge when full and out_ready=1 is required and keeps in_ready=1.
- in_valid without in_ready: operands are not sampled, and the source must hold them.
- Reset mid-operation discards all in-flight beats. out_valid=0 on the cycle after the reset edge, and no stale result appears afterwards.
- BITWIDTH=BLOCK degenerates to a single registered stage with latency 1.

## Structure
- No shared package entries are needed.
- STAGES is a localparam; parameter legality (BITWIDTH % BLOCK == 0, BLOCK ≥ 2) is checked by an elaboration-time generate error.
- Sub-module cla_block (combinational, BLOCK-wide):
  - Inputs: a, b, cin.
  - Outputs: sum, block propagate, block generate, cout, and carry into its MSB (for overflow).
  - Instantiated once per stage.
- Top level holds stage valid regs, skew/deskew data regs and handshake logic.

## Test plan
- 32/8 add: A=0x0000_00FF, B=0x0000_0001, cin=0, sub=0 → sum=0x0000_0100, carry_out=0, overflow=0, valid 4 cycles after acceptance.
- Full carry chain: A=0xFFFF_FFFF, B=0, cin=1 → sum=0, carry_out=1, overflow=0; carry crosses all four stages.
- Signed overflow and subtract, as two separate beats:
  - A=0x7FFF_FFFF + B=1 → sum=0x8000_0000, overflow=1, carry_out=0.
  - sub=1, A=5, B=7, cin=0 → sum=0xFFFF_FFFE, carry_out=0, overflow=0.
- Back-to-back stream: 100 random beats with out_ready=1 → one result per cycle in order, matching a reference model.
- Backpressure: out_ready=0 for 10 cycles with continuous in_valid → exactly 4 beats accepted, in_ready=0, output held stable. Then release → all beats drain in order, none lost.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid=0 on the next cycle and those 3 results never appear. A new beat after reset returns the correct result with latency 4.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared defaults and small helpers for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

  localparam int DEFAULT_BITWIDTH = 32;
  localparam int DEFAULT_BLOCK    = 8;

  // Number of pipeline stages: one BLOCK-wide slice is resolved per stage.
  function automatic int stageCount(input int bitwidth, input int block);
    return bitwidth / block;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_cla_adder_if
  import pipelined_cla_adder_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
);

  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] bits_a;
  logic [BITWIDTH-1:0] bits_b;
  logic                carry_in;
  logic                sub;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] sum;
  logic                carry_out;
  logic                overflow;

  modport master (
    output in_valid,
    output bits_a,
    output bits_b,
    output carry_in,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry_out,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  bits_a,
    input  bits_b,
    input  carry_in,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry_out,
    output overflow
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// Combinational BLOCK-wide carry-lookahead slice. Every internal carry is
// formed directly from the per-bit generate/propagate terms and the slice
// carry-in, so no carry ripples bit to bit inside the slice.
module cla_block
  import pipelined_cla_adder_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             prop_o,
  output logic             gen_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] gen;
  logic [BLOCK:0]   carry;

  // Carry into bit bitIdx as a flat sum of products:
  // g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin.
  function automatic logic carryInto(
    input logic [BLOCK-1:0] genBits,
    input logic [BLOCK-1:0] propBits,
    input logic             cIn,
    input int               bitIdx
  );
    logic acc;
    logic run;
    acc = 1'b0;
    run = 1'b1;
    for (int j = BLOCK - 1; j >= 0; j--) begin
      if (j < bitIdx) begin
        acc = acc | (run & genBits[j]);
        run = run & propBits[j];
      end
    end
    return acc | (run & cIn);
  endfunction

  assign prop = a_i ^ b_i;
  assign gen  = a_i & b_i;

  // Resolve every carry of the slice in parallel from generate/propagate.
  always_comb begin
    carry = '0;
    for (int i = 0; i <= BLOCK; i++) begin
      carry[i] = carryInto(gen, prop, cin_i, i);
    end
  end

  assign sum_o  = prop ^ carry[BLOCK-1:0];
  assign prop_o = &prop;
  assign gen_o  = carryInto(gen, prop, 1'b0, BLOCK);
  assign cout_o = carry[BLOCK];
  assign cmsb_o = carry[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Stage k resolves operand slice k
// with a cla_block, using the slice carry registered by stage k-1. Operands for
// later slices travel forward with the beat and finished low sum slices are
// carried along so the whole result emerges from the last stage at once.
// Each stage has its own valid bit and the stages form an elastic pipeline.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int BLOCK    = DEFAULT_BLOCK
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int STAGES = stageCount(BITWIDTH, BLOCK);

  if ((BLOCK < 2) || (BITWIDTH < BLOCK) || ((BITWIDTH % BLOCK) != 0)) begin : gParamCheck
    $error("pipelined_cla_adder: BITWIDTH must be a multiple of BLOCK, at least BLOCK, and BLOCK must be at least 2");
  end

  // Stage registers: index k holds what stage k produced for its beat.
  logic                valid_q [STAGES];
  logic                valid_d [STAGES];
  logic [BITWIDTH-1:0] a_q     [STAGES];
  logic [BITWIDTH-1:0] a_d     [STAGES];
  logic [BITWIDTH-1:0] b_q     [STAGES];
  logic [BITWIDTH-1:0] b_d     [STAGES];
  logic [BITWIDTH-1:0] sum_q   [STAGES];
  logic [BITWIDTH-1:0] sum_d   [STAGES];
  logic                carry_q [STAGES];
  logic                carry_d [STAGES];
  logic                ovf_q;
  logic                ovf_d;

  // What each stage sees on its input side.
  logic [BITWIDTH-1:0] stageA     [STAGES];
  logic [BITWIDTH-1:0] stageB     [STAGES];
  logic [BITWIDTH-1:0] stageSum   [STAGES];
  logic                stageCarry [STAGES];
  logic                stageValid [STAGES];

  // Per-stage lookahead results.
  logic [BLOCK-1:0]    sliceSum  [STAGES];
  logic                sliceProp [STAGES];
  logic                sliceGen  [STAGES];
  logic                sliceCout [STAGES];
  logic                sliceCmsb [STAGES];

  logic                ready [STAGES+1];
  logic                inReady;
  logic                unusedFold;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    cla_block #(
      .BLOCK(BLOCK)
    ) uCla (
      .a_i   (stageA[k][k*BLOCK +: BLOCK]),
      .b_i   (stageB[k][k*BLOCK +: BLOCK]),
      .cin_i (stageCarry[k]),
      .sum_o (sliceSum[k]),
      .prop_o(sliceProp[k]),
      .gen_o (sliceGen[k]),
      .cout_o(sliceCout[k]),
      .cmsb_o(sliceCmsb[k])
    );
  end

  // A stage may load when it is empty or its beat moves on this cycle;
  // the input is held off entirely while reset is asserted.
  always_comb begin
    ready[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
    inReady = ready[0] && !rst;
  end

  // Stage 0 takes the effective operands from the bus; later stages take the
  // registers of the stage before them.
  always_comb begin
    stageA[0]     = bus.bits_a;
    stageB[0]     = bus.sub ? ~bus.bits_b : bus.bits_b;
    stageSum[0]   = '0;
    stageCarry[0] = bus.carry_in ^ bus.sub;
    stageValid[0] = bus.in_valid && inReady;
    for (int k = 1; k < STAGES; k++) begin
      stageA[k]     = a_q[k-1];
      stageB[k]     = b_q[k-1];
      stageSum[k]   = sum_q[k-1];
      stageCarry[k] = carry_q[k-1];
      stageValid[k] = valid_q[k-1];
    end
  end

  // Next state: a stage refreshes its valid bit whenever it may load, and
  // captures new data only for a real beat so a stalled result stays put.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = stageValid[k];
      end
      if (ready[k] && stageValid[k]) begin
        a_d[k]                       = stageA[k];
        b_d[k]                       = stageB[k];
        sum_d[k]                     = stageSum[k];
        sum_d[k][k*BLOCK +: BLOCK]   = sliceSum[k];
        carry_d[k]                   = sliceCout[k];
      end
    end
    if (ready[STAGES-1] && stageValid[STAGES-1]) begin
      ovf_d = sliceCmsb[STAGES-1] ^ sliceCout[STAGES-1];
    end
  end

  // Pipeline registers with synchronous reset that drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand copies in the last stage and the slice propagate/generate terms
  // have no consumer; fold them here so they are visibly intentional.
  always_comb begin
    unusedFold = ^{a_q[STAGES-1], b_q[STAGES-1]};
    for (int k = 0; k < STAGES; k++) begin
      unusedFold = unusedFold ^ sliceProp[k] ^ sliceGen[k] ^ sliceCmsb[k];
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.carry_out = carry_q[STAGES-1];
  assign bus.overflow  = ovf_q;

endmodule
